// File: rtl/axil_isram_slv.sv
// AXI-Lite read-only instruction SRAM slave with a program-load write port.
// One outstanding read; the response appears a fixed number of cycles after
// the address handshake and is held until the master accepts it.
module axil_isram_slv #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     slv_ar_valid_i,
  input  logic [31:0]              slv_ar_addr_i,
  output logic                     slv_ar_ready_o,
  output logic                     slv_r_valid_o,
  output logic [31:0]              slv_r_data_o,
  output logic [1:0]               slv_r_resp_o,
  input  logic                     slv_r_ready_i,
  input  logic                     ld_en_i,
  input  logic [$clog2(DEPTH)-1:0] ld_idx_i,
  input  logic [31:0]              ld_data_i
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] SPAN_LAST = ADDR_W'(DEPTH * 4 - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   lk_addr;
  logic [ADDR_W-1:0]   lk_offset;
  logic [IDX_W-1:0]    lk_idx;
  logic                lk_below;
  logic                lk_beyond;
  logic [DATA_W-1:0]   lk_data;
  logic [1:0]          lk_resp;

  // Handshake flags come straight from the state register.
  assign slv_ar_ready_o = (state_q == S_IDLE);
  assign slv_r_valid_o  = (state_q == S_RESP);
  assign slv_r_data_o   = rdata_q;
  assign slv_r_resp_o   = rresp_q;

  // Program-load port; the array is never reset.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem[ld_idx_i] <= ld_data_i;
    end
  end

  // Decode the read address: live bus address when the response is captured
  // on the handshake edge itself, latched address otherwise.
  always_comb begin
    lk_addr   = (state_q == S_IDLE) ? slv_ar_addr_i : addr_q;
    lk_offset = lk_addr - BASE_ADDR;
    lk_below  = (lk_addr < BASE_ADDR);
    lk_beyond = (lk_offset > SPAN_LAST);
    lk_idx    = lk_offset[IDX_W+1:2];
    lk_data   = '0;
    lk_resp   = RESP_OKAY;
    if (lk_below || lk_beyond) begin
      lk_resp = RESP_DECERR;
    end else if (lk_addr[1:0] != 2'b00) begin
      lk_resp = RESP_SLVERR;
    end else begin
      lk_data = mem[lk_idx];
    end
  end

  // Next-state, countdown and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      S_IDLE: begin
        if (slv_ar_valid_i) begin
          addr_d = slv_ar_addr_i;
          cnt_d  = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            rdata_d = lk_data;
            rresp_d = lk_resp;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rdata_d = lk_data;
          rresp_d = lk_resp;
        end
      end
      S_RESP: begin
        if (slv_r_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers; reset aborts any read in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_isram_slv.sv
// Bench for axil_isram_slv: two instances (LATENCY 2 and 1) share one stimulus
// stream; a monitor checks each against a word-array reference model.
module tb_axil_isram_slv;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned IW    = 12;
  localparam int          BOUND = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ar_valid = 1'b0;
  logic [31:0] ar_addr = '0;
  logic        r_ready = 1'b0;
  logic        ld_en = 1'b0;
  logic [IW-1:0] ld_idx = '0;
  logic [31:0] ld_data = '0;

  logic [1:0]  ar_rdy;
  logic [1:0]  r_vld;
  logic [31:0] r_data [2];
  logic [1:0]  r_resp [2];

  always #5 clk = ~clk;

  axil_isram_slv #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_addr_i(ar_addr), .slv_ar_ready_o(ar_rdy[0]),
    .slv_r_valid_o(r_vld[0]), .slv_r_data_o(r_data[0]), .slv_r_resp_o(r_resp[0]),
    .slv_r_ready_i(r_ready),
    .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data)
  );

  axil_isram_slv #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_addr_i(ar_addr), .slv_ar_ready_o(ar_rdy[1]),
    .slv_r_valid_o(r_vld[1]), .slv_r_data_o(r_data[1]), .slv_r_resp_o(r_resp[1]),
    .slv_r_ready_i(r_ready),
    .ld_en_i(ld_en), .ld_idx_i(ld_idx), .ld_data_i(ld_data)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model_mem [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          out [2];
  int          due [2];
  int          ptr [2];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference: byte-address window test, alignment test, then word fetch.
  function automatic void ref_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    longint unsigned ua, lo, hi;
    ua = 64'(a);
    lo = 64'(BASE);
    hi = lo + 64'(DEPTH) * 4;
    d  = '0;
    if (ua < lo || ua >= hi) r = 2'b11;
    else if (ua % 4 != 0)    r = 2'b10;
    else begin
      r = 2'b00;
      d = model_mem[IW'((ua - lo) / 4)];
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(4, 0))
      0, 1:    a = BASE + 32'($urandom_range(63, 0)) * 4;
      2:       a = BASE + 32'($urandom_range(63, 0)) * 4 + 32'($urandom_range(3, 1));
      3:       a = 32'($urandom_range(32'h7FFF_FFFF, 0));
      default: a = 32'h8000_4000 + 32'($urandom_range(32'h7FFF_BFFF, 0));
    endcase
    return a;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: per instance, check handshake flags, response timing and payload.
  initial begin
    for (int i = 0; i < 2; i++) begin
      out[i] = 1'b0; due[i] = 0; ptr[i] = 0;
    end
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          out[i] = 1'b0;
          ptr[i] = exp_q.size();
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit exp_v;
          exp_v = out[i] && (cyc >= due[i]);
          check($sformatf("u%0d ar_ready", i), 32'(ar_rdy[i]), 32'(!out[i]));
          check($sformatf("u%0d r_valid", i), 32'(r_vld[i]), 32'(exp_v));
          if (r_vld[i] && ptr[i] < exp_q.size()) begin
            check($sformatf("u%0d r_data", i), r_data[i], exp_q[ptr[i]].d);
            check($sformatf("u%0d r_resp", i), 32'(r_resp[i]), 32'(exp_q[ptr[i]].r));
            if (r_ready) begin
              ptr[i]++;
              out[i] = 1'b0;
            end
          end
          if (ar_valid && ar_rdy[i]) begin
            out[i] = 1'b1;
            due[i] = cyc + lat_of(i);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    model_mem[idx] = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    exp_t e;
    ref_read(a, e.d, e.r);
    exp_q.push_back(e);
    ar_valid = 1'b1;
    ar_addr  = a;
  endtask

  task automatic wait_out(input bit want, input string what);
    int n = 0;
    while (!(out[0] == want && out[1] == want) && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got no handshake expected one within %0d cycles", what, BOUND);
    end
  endtask

  task automatic wait_vld();
    int n = 0;
    while (r_vld != 2'b11 && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) begin
      n_tests++; n_fail++;
      $display("FAIL r_valid timeout: got %b expected 11", r_vld);
    end
  endtask

  // One read; optionally a load on the next edge, and a second AR presented
  // while the first response waits.
  task automatic do_read(input logic [31:0] a, input int hold, input bit pre,
                         input bit amb, input logic [31:0] amb_a, input bit ld_mid);
    if (!pre) issue(a);
    wait_out(1'b1, "ar");
    ar_valid = 1'b0;
    if (ld_mid) load(IW'(1), 32'hDEAD_BEEF);
    wait_vld();
    if (amb) issue(amb_a);
    repeat (hold) tick();
    r_ready = 1'b1;
    wait_out(1'b0, "r");
    r_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend;
    logic [31:0] pend_a;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d reset ar_ready", i), 32'(ar_rdy[i]), 32'd1);
      check($sformatf("u%0d reset r_valid", i), 32'(r_vld[i]), 32'd0);
      check($sformatf("u%0d reset r_data", i), r_data[i], 32'd0);
      check($sformatf("u%0d reset r_resp", i), 32'(r_resp[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    load(IW'(0), 32'h0000_0013);
    load(IW'(1), 32'h1111_1111);
    for (int k = 2; k < 64; k++) load(IW'(k), $urandom());
    load(IW'(DEPTH - 1), 32'hCAFE_F00D);

    do_read(BASE, 0, 0, 0, 0, 0);
    do_read(32'h8000_0006, 1, 0, 0, 0, 0);
    do_read(32'h7FFF_FFFC, 0, 0, 0, 0, 0);
    do_read(32'h8000_4000, 0, 0, 0, 0, 0);
    do_read(32'h8000_4002, 0, 0, 0, 0, 0);
    do_read(32'h8000_3FFC, 0, 0, 0, 0, 0);
    do_read(32'hFFFF_FFFC, 0, 0, 0, 0, 0);

    do_read(BASE + 32'd8, 5, 0, 1, BASE + 32'd12, 0);
    do_read(BASE + 32'd12, 0, 1, 0, 0, 0);

    do_read(BASE + 32'd4, 0, 0, 0, 0, 1);
    do_read(BASE + 32'd4, 0, 0, 0, 0, 0);

    // Reset while the LATENCY=2 instance is in BUSY and the other in RESP.
    issue(BASE + 32'd16);
    wait_out(1'b1, "ar");
    ar_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid-reset ar_ready", 32'(ar_rdy), 32'h3);
    check("mid-reset r_valid", 32'(r_vld), 32'h0);
    check("mid-reset u1 r_data", r_data[1], 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (6) tick();
    check("post-reset r_valid", 32'(r_vld), 32'h0);
    check("post-reset ar_ready", 32'(ar_rdy), 32'h3);
    do_read(BASE + 32'd16, 0, 0, 0, 0, 0);

    pend = 1'b0;
    pend_a = '0;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      bit          amb;
      if (!pend && $urandom_range(2, 0) == 0) load(IW'($urandom_range(63, 0)), $urandom());
      a   = pend ? pend_a : rand_addr();
      amb = ($urandom_range(3, 0) == 0);
      pend_a = rand_addr();
      do_read(a, $urandom_range(3, 0), pend, amb, pend_a, 0);
      pend = amb;
    end
    if (pend) do_read(pend_a, 0, 1, 0, 0, 0);

    repeat (3) tick();
    check("u0 all responses seen", 32'(ptr[0]), 32'(exp_q.size()));
    check("u1 all responses seen", 32'(ptr[1]), 32'(exp_q.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
